// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DMEM_DEPTH       = 256;
  localparam int unsigned DMEM_WAIT_STATES = 2;

  // Bits needed to index DEPTH halfwords (never less than one).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Halfword storage: one write port, one registered read port, async clear.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH = DMEM_DEPTH,
  localparam int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata
);

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  // Storage and read register; read data falls back to zero when not reading.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i[IDX_W-1:0]] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= i_re ? r_mem[i_addr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data memory responder: valid/ready request, fixed wait states,
// single-cycle response with read data or error flag.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DMEM_DEPTH,
  parameter int unsigned WAIT_STATES = DMEM_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  state_e             r_state;
  state_e             w_next_state;
  logic [3:0]         r_wait_cnt;
  logic               r_write;
  logic [15:0]        r_addr;
  logic [15:0]        r_wdata;
  logic               r_err;

  logic               w_cur_write;
  logic [15:0]        w_cur_addr;
  logic [15:0]        w_cur_wdata;
  logic               w_err;
  logic               w_enter_resp;
  logic [IDX_W-1:0]   w_idx;
  logic [15:0]        w_rdata;

  // With zero wait states the commit edge is the accept edge, so the live
  // request is used there instead of the (not yet loaded) latched copy.
  always_comb begin
    w_cur_write = r_write;
    w_cur_addr  = r_addr;
    w_cur_wdata = r_wdata;
    if (r_state == ST_IDLE) begin
      w_cur_write = req_write;
      w_cur_addr  = req_addr;
      w_cur_wdata = req_wdata;
    end
  end

  assign w_err        = w_cur_addr[0] || (32'(w_cur_addr[15:1]) >= DEPTH);
  assign w_enter_resp = (w_next_state == ST_RESP);
  assign w_idx        = w_cur_addr[IDX_W:1];

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_wait_cnt == 4'd1) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register, wait counter, request latch and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && req_valid) begin
        r_wait_cnt <= 4'(WAIT_STATES);
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      r_err <= w_enter_resp && w_err;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_enter_resp && w_cur_write && !w_err),
    .i_re    (w_enter_resp && !w_cur_write && !w_err),
    .i_addr  (w_idx),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_rdata)
  );

  // Read data and error registers clear on every non-commit edge, so they
  // are already zero whenever resp_valid is low.
  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = w_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (WAIT_STATES=2 and =0 instances).
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [15:0] resp_rdata;

  logic        req_valid0, req_write0;
  logic [15:0] req_addr0, req_wdata0;
  logic        req_ready0, resp_valid0, resp_err0, busy0;
  logic [15:0] resp_rdata0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  data_memory_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_ready(req_ready0),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
  );

  // One access on u_dut; entered just after a rising edge with the DUT idle.
  // lat = n means resp_valid seen in the cycle after edge k+n, where edge k
  // is the edge preceding the request being driven. lat = -1 on timeout.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    rd = '0; er = 1'b0; lat = -1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(negedge clk);
      if (resp_valid) begin rd = resp_rdata; er = resp_err; lat = n; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] rd; logic er; int lat;
    @(negedge clk);
    n_checks += 5;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    if (resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", resp_rdata); end
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    // Store issued immediately; first edge after release must accept it.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL first_accept_busy: got %b expected 1", busy); end
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL first_accept_ready: got %b expected 0", req_ready); end
    #1 rst = 1'b0;
    #1;
    n_checks += 5;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midwait_rst_ready: got %b expected 1", req_ready); end
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_rst_valid: got %b expected 0", resp_valid); end
    if (resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL midwait_rst_rdata: got %h expected 0000", resp_rdata); end
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL midwait_rst_err: got %b expected 0", resp_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midwait_rst_busy: got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp: got %b expected 0", resp_valid); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    access(1'b0, 16'h0010, 16'h0000, rd, er, lat);
    n_checks += 3;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL post_rst_load_data: got %h expected 0000", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL post_rst_load_err: got %b expected 0", er); end
    if (lat !== 3) begin n_fail++; $display("FAIL post_rst_load_lat: got %0d expected 3", lat); end
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic er; int lat;
    access(1'b1, 16'h0004, 16'hBEEF, rd, er, lat);
    n_checks += 3;
    if (lat !== 3) begin n_fail++; $display("FAIL store_lat: got %0d expected 3", lat); end
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL store_rdata: got %h expected 0000", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
    n_checks += 2;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_one_cycle: got %b expected 0", resp_valid); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_resp: got %b expected 1", req_ready); end
    access(1'b0, 16'h0004, 16'h0000, rd, er, lat);
    n_checks += 3;
    if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL load_data: got %h expected beef", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b expected 0", er); end
    if (lat !== 3) begin n_fail++; $display("FAIL load_lat: got %0d expected 3", lat); end
    access(1'b1, 16'h0004, 16'h1357, rd, er, lat);
    access(1'b0, 16'h0004, 16'h0000, rd, er, lat);
    n_checks++;
    if (rd !== 16'h1357) begin n_fail++; $display("FAIL overwrite_data: got %h expected 1357", rd); end
  endtask

  task automatic test_misaligned();
    logic [15:0] rd; logic er; int lat;
    access(1'b1, 16'h0003, 16'h1234, rd, er, lat);
    n_checks += 2;
    if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_st_err: got %b expected 1", er); end
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL misalign_st_rdata: got %h expected 0000", rd); end
    access(1'b0, 16'h0002, 16'h0000, rd, er, lat);
    n_checks += 2;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL misalign_no_write: got %h expected 0000", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL aligned_err: got %b expected 0", er); end
    access(1'b0, 16'h0005, 16'h0000, rd, er, lat);
    n_checks += 2;
    if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_ld_err: got %b expected 1", er); end
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL misalign_ld_rdata: got %h expected 0000", rd); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic er; int lat;
    access(1'b0, 16'h0200, 16'h0000, rd, er, lat);
    n_checks += 2;
    if (er !== 1'b1) begin n_fail++; $display("FAIL oor_ld_err: got %b expected 1", er); end
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL oor_ld_rdata: got %h expected 0000", rd); end
    access(1'b1, 16'h01FE, 16'hA5A5, rd, er, lat);
    access(1'b0, 16'h01FE, 16'h0000, rd, er, lat);
    n_checks += 2;
    if (er !== 1'b0) begin n_fail++; $display("FAIL top_word_err: got %b expected 0", er); end
    if (rd !== 16'hA5A5) begin n_fail++; $display("FAIL top_word_data: got %h expected a5a5", rd); end
    // 0x0200 aliases index 0 in the low bits; the rejected store must not land there.
    access(1'b1, 16'h0200, 16'h6666, rd, er, lat);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL oor_st_err: got %b expected 1", er); end
    access(1'b0, 16'h0000, 16'h0000, rd, er, lat);
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL oor_no_alias: got %h expected 0000", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int lat;
    int accepts = 0;
    for (int c = 0; c < 16; c++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr  = 16'h0040 + 16'(2 * c);
      req_wdata = 16'hC000 + 16'(c);
      @(negedge clk);
      if (req_ready === 1'b1) accepts++;
      n_checks += 4;
      if (req_ready !== ((c % 4) == 0)) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b expected %b", c, req_ready, (c % 4) == 0); end
      if (busy !== ((c % 4) != 0)) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy, (c % 4) != 0); end
      if (resp_valid !== ((c % 4) == 3)) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, resp_valid, (c % 4) == 3); end
      if (resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL b2b_rdata c=%0d: got %h expected 0000", c, resp_rdata); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_checks++;
    if (accepts !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", accepts); end
    for (int c = 0; c < 16; c++) begin
      access(1'b0, 16'h0040 + 16'(2 * c), 16'h0000, rd, er, lat);
      n_checks++;
      if (rd !== (((c % 4) == 0) ? 16'hC000 + 16'(c) : 16'h0000)) begin
        n_fail++;
        $display("FAIL b2b_readback c=%0d: got %h expected %h", c, rd, ((c % 4) == 0) ? 16'hC000 + 16'(c) : 16'h0000);
      end
    end
  endtask

  task automatic test_zero_wait();
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 16'h0006; req_wdata0 = 16'h7777;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (resp_valid0 !== 1'b1) begin n_fail++; $display("FAIL zw_st_valid: got %b expected 1", resp_valid0); end
    if (req_ready0 !== 1'b0) begin n_fail++; $display("FAIL zw_st_ready: got %b expected 0", req_ready0); end
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL zw_st_busy: got %b expected 1", busy0); end
    if (resp_rdata0 !== 16'h0000) begin n_fail++; $display("FAIL zw_st_rdata: got %h expected 0000", resp_rdata0); end
    @(negedge clk);
    n_checks += 3;
    if (req_ready0 !== 1'b1) begin n_fail++; $display("FAIL zw_ready_back: got %b expected 1", req_ready0); end
    if (resp_valid0 !== 1'b0) begin n_fail++; $display("FAIL zw_valid_drop: got %b expected 0", resp_valid0); end
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL zw_busy_drop: got %b expected 0", busy0); end
    @(posedge clk); #1;
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 16'h0006;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (resp_valid0 !== 1'b1) begin n_fail++; $display("FAIL zw_ld_valid: got %b expected 1", resp_valid0); end
    if (resp_rdata0 !== 16'h7777) begin n_fail++; $display("FAIL zw_ld_data: got %h expected 7777", resp_rdata0); end
    if (resp_err0 !== 1'b0) begin n_fail++; $display("FAIL zw_ld_err: got %b expected 0", resp_err0); end
    @(posedge clk); #1;
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 16'h0007;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (resp_err0 !== 1'b1) begin n_fail++; $display("FAIL zw_misalign_err: got %b expected 1", resp_err0); end
    if (resp_rdata0 !== 16'h0000) begin n_fail++; $display("FAIL zw_misalign_rdata: got %h expected 0000", resp_rdata0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_clears_array();
    logic [15:0] rd; logic er; int lat;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    access(1'b0, 16'h01FE, 16'h0000, rd, er, lat);
    n_checks++;
    if (rd !== 16'h0000) begin n_fail++; $display("FAIL rst_clear_data: got %h expected 0000", rd); end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_zero_wait();
    test_reset_clears_array();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
